adxl362_spi_responder: RTL

Synthesizable SPI responder that models the ADXL362 register interface. It answers mode-0 register write (0x0A) and register read (0x0B) transactions from the accelerometer SPI master. The block sits in place of the physical sensor for hardware-in-the-loop and simulation runs, and serves acceleration samples supplied on its input ports.

---
 rtl/adxl362_pkg.sv | 67 ++++++
 rtl/spi_edge_sync.sv | 31 +++
 rtl/adxl362_spi_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants, register map helpers and FSM state type for the ADXL362 responder.
// ADXL_RESP_SOFT_RESET_EN makes 0x1F writable (soft-reset key register).
package adxl362_pkg;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD     = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST    = 6'h01;
  localparam logic [5:0] ADDR_PARTID       = 6'h02;
  localparam logic [5:0] ADDR_REVID        = 6'h03;
  localparam logic [5:0] ADDR_XDATA        = 6'h08;
  localparam logic [5:0] ADDR_YDATA        = 6'h09;
  localparam logic [5:0] ADDR_ZDATA        = 6'h0A;
  localparam logic [5:0] ADDR_STATUS       = 6'h0B;
  localparam logic [5:0] ADDR_XDATA_L      = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H      = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L      = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H      = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L      = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H      = 6'h13;
  localparam logic [5:0] ADDR_SOFT_RESET   = 6'h1F;
  localparam logic [5:0] ADDR_WR_FIRST     = 6'h20;
  localparam logic [5:0] ADDR_FIFO_SAMPLES = 6'h28;
  localparam logic [5:0] ADDR_FILTER_CTL   = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL    = 6'h2D;
  localparam logic [5:0] ADDR_WR_LAST      = 6'h2E;

  localparam logic [7:0] ID_DEVID_AD      = 8'hAD;
  localparam logic [7:0] ID_DEVID_MST     = 8'h1D;
  localparam logic [7:0] ID_PARTID        = 8'hF2;
  localparam logic [7:0] ID_REVID         = 8'h01;
  localparam logic [7:0] DEF_FIFO_SAMPLES = 8'h80;
  localparam logic [7:0] DEF_FILTER_CTL   = 8'h13;
  localparam logic [7:0] SOFT_RESET_KEY   = 8'h52;

  // Backing store covers 0x1F..0x2E; entry 0 stays 0 unless soft reset is built in.
  localparam int NUM_WREGS = 16;
  typedef logic [NUM_WREGS-1:0][7:0] wregs_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_e;

  function automatic logic [3:0] wreg_idx(input logic [5:0] a);
    return 4'(a - ADDR_SOFT_RESET);
  endfunction

  function automatic wregs_t wreg_defaults();
    wregs_t r;
    r = '0;
    r[wreg_idx(ADDR_FIFO_SAMPLES)] = DEF_FIFO_SAMPLES;
    r[wreg_idx(ADDR_FILTER_CTL)]   = DEF_FILTER_CTL;
    return r;
  endfunction

  localparam wregs_t WREG_DEFAULTS = wreg_defaults();

  function automatic logic wreg_writable(input logic [5:0] a);
`ifdef ADXL_RESP_SOFT_RESET_EN
    return (a >= ADDR_SOFT_RESET) && (a <= ADDR_WR_LAST);
`else
    return (a >= ADDR_WR_FIRST) && (a <= ADDR_WR_LAST);
`endif
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 register interface (0x0A write, 0x0B read).
// Optional ADXL_RESP_SOFT_RESET_EN: writing 0x52 to 0x1F restores writable registers.
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic [15:0] i_xdata,
  input  logic [15:0] i_ydata,
  input  logic [15:0] i_zdata,
  input  logic        i_sample_valid,
  output logic [7:0]  o_power_ctl,
  output logic [7:0]  o_filter_ctl,
  output logic        o_measure,
  output logic        o_wr_valid,
  output logic [5:0]  o_wr_addr,
  output logic [7:0]  o_wr_data
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i_sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // CS_n resets low so a frame already in progress at reset yields no falling edge.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i_cs_n),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(i_clk), .rst_i(i_rst), .d_i(i_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign sync_unused = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [5:0]  addr_q, addr_d;
  logic        rd_cmd_q, rd_cmd_d;
  logic [7:0]  tx_q, tx_d;
  logic        rd_hit_q, rd_hit_d;
  logic        dr_q, dr_d;
  logic [15:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d, snap_z_q, snap_z_d;
  wregs_t      wregs_q, wregs_d;
  logic        wr_valid_q, wr_valid_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
`ifdef ADXL_RESP_SOFT_RESET_EN
  logic        soft_pend_q, soft_pend_d;
`endif

  logic [7:0]  byte_in;
  logic        byte_done;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_byte;

  assign byte_in   = {shift_q, mosi_lvl};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  // Address of the byte to preload: the one just received, or the next sequential one.
  assign rd_addr   = (state_q == ST_ADDR) ? byte_in[5:0] : addr_q + 6'd1;

  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_byte = ID_DEVID_AD;
      ADDR_DEVID_MST: rd_byte = ID_DEVID_MST;
      ADDR_PARTID:    rd_byte = ID_PARTID;
      ADDR_REVID:     rd_byte = ID_REVID;
      ADDR_XDATA:     rd_byte = snap_x_q[15:8];
      ADDR_YDATA:     rd_byte = snap_y_q[15:8];
      ADDR_ZDATA:     rd_byte = snap_z_q[15:8];
      ADDR_STATUS:    rd_byte = {7'd0, dr_q};
      ADDR_XDATA_L:   rd_byte = snap_x_q[7:0];
      ADDR_XDATA_H:   rd_byte = snap_x_q[15:8];
      ADDR_YDATA_L:   rd_byte = snap_y_q[7:0];
      ADDR_YDATA_H:   rd_byte = snap_y_q[15:8];
      ADDR_ZDATA_L:   rd_byte = snap_z_q[7:0];
      ADDR_ZDATA_H:   rd_byte = snap_z_q[15:8];
      default: if (wreg_writable(rd_addr)) rd_byte = wregs_q[wreg_idx(rd_addr)];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    rd_cmd_d   = rd_cmd_q;
    tx_d       = tx_q;
    rd_hit_d   = rd_hit_q;
    dr_d       = dr_q;
    snap_x_d   = snap_x_q;
    snap_y_d   = snap_y_q;
    snap_z_d   = snap_z_q;
    wregs_d    = wregs_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef ADXL_RESP_SOFT_RESET_EN
    soft_pend_d = 1'b0;
    if (soft_pend_q) wregs_d = WREG_DEFAULTS;
`endif

    if (sclk_rise && state_q != ST_IDLE) begin
      shift_d   = byte_in[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The fall right after a byte load keeps the freshly loaded MSB on the line.
    if (sclk_fall && state_q == ST_RDATA && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
    if (sclk_rise && state_q == ST_RDATA && addr_q >= ADDR_XDATA_L && addr_q <= ADDR_ZDATA_H)
      rd_hit_d = 1'b1;

    if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          if (byte_in == CMD_WR || byte_in == CMD_RD) begin
            state_d  = ST_ADDR;
            rd_cmd_d = (byte_in == CMD_RD);
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          addr_d = byte_in[5:0];
          if (rd_cmd_q) begin
            state_d = ST_RDATA;
            tx_d    = rd_byte;
          end else begin
            state_d = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (wreg_writable(addr_q)) begin
            wregs_d[wreg_idx(addr_q)] = byte_in;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = byte_in;
`ifdef ADXL_RESP_SOFT_RESET_EN
            if (addr_q == ADDR_SOFT_RESET && byte_in == SOFT_RESET_KEY) soft_pend_d = 1'b1;
`endif
          end
          addr_d = addr_q + 6'd1;
        end
        ST_RDATA: begin
          addr_d = addr_q + 6'd1;
          tx_d   = rd_byte;
        end
        default: ;
      endcase
    end

    if (cs_fall) begin
      snap_x_d = i_xdata;
      snap_y_d = i_ydata;
      snap_z_d = i_zdata;
      rd_hit_d = 1'b0;
      if (state_q == ST_IDLE) begin
        state_d   = ST_CMD;
        bit_cnt_d = 3'd0;
      end
    end
    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      if (rd_hit_q) dr_d = 1'b0;
    end
    if (i_sample_valid) dr_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      addr_q     <= 6'd0;
      rd_cmd_q   <= 1'b0;
      tx_q       <= 8'd0;
      rd_hit_q   <= 1'b0;
      dr_q       <= 1'b0;
      snap_x_q   <= 16'd0;
      snap_y_q   <= 16'd0;
      snap_z_q   <= 16'd0;
      wregs_q    <= WREG_DEFAULTS;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 8'd0;
`ifdef ADXL_RESP_SOFT_RESET_EN
      soft_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      rd_cmd_q   <= rd_cmd_d;
      tx_q       <= tx_d;
      rd_hit_q   <= rd_hit_d;
      dr_q       <= dr_d;
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_z_q   <= snap_z_d;
      wregs_q    <= wregs_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef ADXL_RESP_SOFT_RESET_EN
      soft_pend_q <= soft_pend_d;
`endif
    end
  end

  assign o_miso       = (state_q == ST_RDATA) ? tx_q[7] : 1'b0;
  assign o_power_ctl  = wregs_q[wreg_idx(ADDR_POWER_CTL)];
  assign o_filter_ctl = wregs_q[wreg_idx(ADDR_FILTER_CTL)];
  assign o_measure    = (o_power_ctl[1:0] == 2'b10);
  assign o_wr_valid   = wr_valid_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;

endmodule
